// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel/coordinate types and the fill-engine state encoding.
package fb_pkg;

  localparam int WIDTH = 12;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int ADDRW = 19;

  typedef logic [WIDTH-1:0] pixel_t;
  typedef logic [9:0]       coord_x_t;
  typedef logic [8:0]       coord_y_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL
  } fill_state_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational bounds check for a fill rectangle: effective extent plus reject flag.
// RECT_CLIP_EN selects clipping to the screen instead of rejecting out-of-range commands.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int HRES = H_RES,
  parameter int VRES = V_RES
) (
  input  coord_x_t x,
  input  coord_y_t y,
  input  coord_x_t w,
  input  coord_y_t h,
  output coord_x_t w_eff,
  output coord_y_t h_eff,
  output logic     reject
);

`ifdef RECT_CLIP_EN
  logic [10:0] x_room;
  logic [9:0]  y_room;

  // An origin off-screen yields an empty rectangle, never an error.
  always_comb begin
    x_room = 11'(HRES) - {1'b0, x};
    y_room = 10'(VRES) - {1'b0, y};
    reject = 1'b0;
    w_eff  = '0;
    h_eff  = '0;
    if (({1'b0, x} < 11'(HRES)) && ({1'b0, y} < 10'(VRES))) begin
      w_eff = ({1'b0, w} > x_room) ? x_room[9:0] : w;
      h_eff = ({1'b0, h} > y_room) ? y_room[8:0] : h;
    end
  end
`else
  logic [10:0] x_end;
  logic [9:0]  y_end;

  assign x_end  = {1'b0, x} + {1'b0, w};
  assign y_end  = {1'b0, y} + {1'b0, h};
  assign reject = (x_end > 11'(HRES)) || (y_end > 10'(VRES));
  assign w_eff  = w;
  assign h_eff  = h;
`endif

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill write initiator for the framebuffer RAM write port (one pixel per clock).
// Build with RECT_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module fb_rect_fill #(
  parameter int WIDTH = fb_pkg::WIDTH,
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES,
  parameter int ADDRW = fb_pkg::ADDRW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [9:0]       cmd_x,
  input  logic [8:0]       cmd_y,
  input  logic [9:0]       cmd_w,
  input  logic [8:0]       cmd_h,
  input  logic [WIDTH-1:0] cmd_color,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ADDRW-1:0] wraddress,
  output logic [WIDTH-1:0] data,
  output logic             wren
);
  import fb_pkg::*;

  fill_state_t      state;
  coord_x_t         x_q, w_q;
  coord_y_t         y_q, h_q;
  logic [WIDTH-1:0] color_q;
  logic [10:0]      cx, x_last;
  logic [9:0]       cy, y_last;
  logic [ADDRW-1:0] row_base;
  logic [ADDRW-1:0] base_setup;
  coord_x_t         w_eff;
  coord_y_t         h_eff;
  logic             reject;
  logic             accept;
  logic             last_col, last_pix;

  fb_rect_clip #(
    .HRES(H_RES),
    .VRES(V_RES)
  ) u_clip (
    .x     (x_q),
    .y     (y_q),
    .w     (w_q),
    .h     (h_q),
    .w_eff (w_eff),
    .h_eff (h_eff),
    .reject(reject)
  );

  // The only multiply; later rows step the base by H_RES.
  assign base_setup = ADDRW'(y_q) * ADDRW'(H_RES);
  assign accept     = cmd_valid && cmd_ready;
  assign last_col   = (cx == x_last);
  assign last_pix   = last_col && (cy == y_last);

  // Command copy and scan counters; qualified by state, so no reset needed.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        if (accept) begin
          x_q     <= cmd_x;
          y_q     <= cmd_y;
          w_q     <= cmd_w;
          h_q     <= cmd_h;
          color_q <= cmd_color;
        end
      end
      SETUP: begin
        cx       <= 11'(x_q);
        cy       <= 10'(y_q);
        row_base <= base_setup;
        x_last   <= 11'(x_q) + 11'(w_eff) - 11'd1;
        y_last   <= 10'(y_q) + 10'(h_eff) - 10'd1;
      end
      FILL: begin
        if (!last_pix) begin
          if (last_col) begin
            cx       <= 11'(x_q);
            cy       <= cy + 10'd1;
            row_base <= row_base + ADDRW'(H_RES);
          end else begin
            cx <= cx + 11'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Control FSM and registered write port; wren holds the pixel at (cx, cy).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wren      <= 1'b0;
      wraddress <= '0;
      data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          wren <= 1'b0;
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if ((w_eff == '0) || (h_eff == '0) || reject) begin
            state     <= IDLE;
            done      <= 1'b1;
            err       <= reject;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state     <= FILL;
            wren      <= 1'b1;
            data      <= color_q;
            wraddress <= base_setup + ADDRW'(x_q);
          end
        end
        FILL: begin
          if (last_pix) begin
            state     <= IDLE;
            wren      <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (last_col) begin
            wraddress <= row_base + ADDRW'(H_RES) + ADDRW'(x_q);
          end else begin
            wraddress <= row_base + ADDRW'(cx) + ADDRW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          wren      <= 1'b0;
        end
      endcase
    end
  end

endmodule
